// File: rtl/regfile_sb_pkg.sv
// Shared constants for the regfile_sb register file and pending-write scoreboard.
// The write-first bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_sb_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam int SB_W       = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [SB_W-1:0]       SB_ONE   = SB_W'(1);
endpackage

// File: rtl/regfile_sb_sb_counter.sv
// Saturating up/down counter: one increment and two decrement sources per cycle.
// The net delta lands in a single edge; out-of-range results saturate and flag.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] count,
  output logic         ovf,
  output logic         udf
);
  logic [W+1:0] sum;

  // Two spare bits: bit W catches count max + 1, bit W+1 catches a negative result.
  always_comb begin
    sum = {2'b00, count}
        + {{(W+1){1'b0}}, inc}
        - {{(W+1){1'b0}}, dec_a}
        - {{(W+1){1'b0}}, dec_b};
    udf = sum[W+1];
    ovf = !sum[W+1] && sum[W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (udf) begin
      count <= '0;
    end else if (!ovf) begin
      count <= sum[W-1:0];
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (x0 hardwired to zero) with a per-register
// pending-write scoreboard. Optional write-first bypass: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rR1,
  input  logic [REG_ADDR_W-1:0] rR2,
  output logic [XLEN-1:0]       rD1,
  output logic [XLEN-1:0]       rD2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wR,
  input  logic [XLEN-1:0]       wD,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  flush_valid,
  input  logic [REG_ADDR_W-1:0] flush_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  sb_err
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0] regs [NREG];
  logic [SB_W-1:0] cnt  [NREG];
  logic [NREG-1:0] ovf_vec;
  logic [NREG-1:0] udf_vec;
  logic            retire1;
  logic            retire2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wR != REG_ZERO) begin
      regs[wR] <= wD;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign cnt[r]     = '0;
      assign ovf_vec[r] = 1'b0;
      assign udf_vec[r] = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec_wb;
      logic dec_fl;
      assign inc    = issue_valid && issue_rd == REG_ADDR_W'(r);
      assign dec_wb = we          && wR       == REG_ADDR_W'(r);
      assign dec_fl = flush_valid && flush_rd == REG_ADDR_W'(r);
      sb_counter #(.W(SB_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec_a (dec_wb),
        .dec_b (dec_fl),
        .count (cnt[r]),
        .ovf   (ovf_vec[r]),
        .udf   (udf_vec[r])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|ovf_vec || |udf_vec) begin
      sb_err <= 1'b1;
    end
  end

  always_comb begin
    rD1 = '0;
    rD2 = '0;
    if (rR1 != REG_ZERO) rD1 = (BYPASS && we && wR == rR1) ? wD : regs[rR1];
    if (rR2 != REG_ZERO) rD2 = (BYPASS && we && wR == rR2) ? wD : regs[rR2];
  end

  // With bypass, a writeback retiring the last pending write releases the stall
  // in the same cycle, since the forwarded data is already on rDN.
  always_comb begin
    retire1  = BYPASS && we && wR == rR1 && cnt[rR1] == SB_ONE
               && !(issue_valid && issue_rd == rR1);
    retire2  = BYPASS && we && wR == rR2 && cnt[rR2] == SB_ONE
               && !(issue_valid && issue_rd == rR2);
    rs1_busy = (rR1 != REG_ZERO) && (cnt[rR1] != '0) && !retire1;
    rs2_busy = (rR2 != REG_ZERO) && (cnt[rR2] != '0) && !retire2;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Register file read/write end of the writeback path. Writeback supplies the write port (we, wR, wD, where wD is the writeback mux result). Decode reads rs1/rs2 through the two read ports.
- Holds the architectural registers, with x0 hardwired to zero.
- Holds a per-register pending-write scoreboard. The hazard unit uses it to stall decode while an older in-flight instruction will still write a source register.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; index width is $clog2(NREG).
- SB_W, 2, width of each scoreboard counter; maximum in-flight writes per register = 2^SB_W-1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- rR1  in  5  decode read address, port 1.
- rR2  in  5  decode read address, port 2.
- rD1  out  XLEN  read data, port 1.
- rD2  out  XLEN  read data, port 2.
- we  in  1  writeback write enable.
- wR  in  5  writeback destination register.
- wD  in  XLEN  writeback data.
- issue_valid  in  1  instruction leaving ID will write issue_rd.
- issue_rd  in  5  destination of the issuing instruction.
- flush_valid  in  1  ID/EX instruction squashed; undo its pending write.
- flush_rd  in  5  destination of the squashed instruction.
- rs1_busy  out  1  pending-write count of rR1 is nonzero.
- rs2_busy  out  1  pending-write count of rR2 is nonzero.
- sb_err  out  1  sticky: counter overflow or underflow detected.

Behaviour:
- Storage:
  - NREG x XLEN registers.
  - On rst, all registers are cleared to 0 synchronously.
  - Write occurs at the clk rising edge when we=1 and wR!=0. Writes to x0 are ignored.
- Reads are combinational.
  - rD1/rD2 = 0 when the address is 0.
  - Otherwise rD1/rD2 = the stored value, subject to the bypass rule under Optional Feature.
- Scoreboard: one SB_W-bit counter per register. rst clears all counters and sb_err.
  - Per-cycle delta for register r: +1 if issue_valid && issue_rd==r && r!=0; -1 if we && wR==r && r!=0; -1 if flush_valid && flush_rd==r && r!=0.
  - The net delta is applied in one edge. Simultaneous inc/dec on the same register leaves the count unchanged.
  - Overflow (count at max with net +1): the counter holds at max and sb_err is set.
  - Underflow (count 0 with net negative): the counter holds at 0 and sb_err is set.
  - sb_err clears only on rst.
- rs1_busy/rs2_busy are combinational on the current counters: rsN_busy = (count[rRN]!=0), forced to 0 for x0.
  - Exception: if the write port retires the last pending write this cycle (we && wR==rRN && count==1 && no same-cycle issue to rRN), rsN_busy is 0 only when bypass is compiled in. Otherwise it stays 1 for that cycle.
- All outputs after reset: rD*=0, rs*_busy=0, sb_err=0.
- Reset mid-operation: everything clears in one edge. In-flight pipeline state is the pipeline's responsibility to flush in the same cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-first bypass: if we && wR!=0 && wR==rRN, rDN = wD in the same cycle.
  - The busy exception above applies, removing one stall cycle.
- Undefined:
  - Reads return only stored values.
  - A same-cycle write is visible the next cycle; rsN_busy stays asserted through the writeback cycle.

Decomposition:
- Shared package/defines.vh:
  - REG_ADDR_W (5)
  - XLEN
  - REG_ZERO (5'd0)
  - SB_W
- One natural sub-module: sb_counter (a single saturating up/down counter with overflow/underflow flags), instantiated NREG-1 times via generate.

Test Plan:
1. rst, then write x5=0xDEADBEEF (we=1,wR=5) -> next cycle rR1=5 gives rD1=0xDEADBEEF; a write to x0 of 0x1234 leaves rD2=0 for rR2=0.
2. issue_valid rd=7, rR1=7 -> rs1_busy=1; three cycles later we=1,wR=7,wD=0x55 -> with BYPASS_EN rD1=0x55 and rs1_busy=0 in that same cycle; without it both update the next cycle.
3. Issue rd=3 twice, writeback rd=3 once -> rs2_busy (rR2=3) stays 1; second writeback -> 0; sb_err=0.
4. Same-cycle issue rd=9 and writeback rd=9 with count=1 -> count stays 1, rs1_busy=1.
5. issue rd=4 then flush_valid flush_rd=4 -> busy returns to 0; a further flush rd=4 -> sb_err=1, sticky until rst. Four issues to rd=6 with SB_W=2 -> sb_err=1.
6. Assert rst mid-stream with counters nonzero -> next cycle all busy=0, all registers read 0, sb_err=0.
